qkv_stream_loader: RTL and testbench

- Upstream feeder for the attention core.
- Host/DMA writes Q, K and V element vectors into three local buffers. On start, the block issues a one-cycle core start with the tile length, then streams aligned (q[i], k[i], v[i]) triples over a valid/ready handshake, one triple per cycle at full throughput.
- Sits between the control/DMA write path and the attention core's in_valid/in_ready input.

---
 rtl/attn_pkg.sv | 27 ++
 rtl/qkv_elem_buf.sv | 37 +++
 rtl/qkv_stream_loader.sv | 219 +++++++++++++++++++++
 tb/tb_qkv_stream_loader.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/attn_pkg.sv
// Shared definitions for the attention front end.
//   ATTN_DATA_WIDTH : element width of q/k/v, common with the attention core
//   ATTN_K_DEFAULT  : tile length used when a zero length is requested
//   ATTN_MAX_K      : buffer depth and largest legal tile length
//   buf_sel_e       : buffer select encoding on the host write port
//   loader_state_e  : streaming loader state machine states
package attn_pkg;

  localparam int ATTN_DATA_WIDTH = 16;
  localparam int ATTN_K_DEFAULT  = 16;
  localparam int ATTN_MAX_K      = 64;

  typedef enum logic [1:0] {
    SEL_Q    = 2'd0,
    SEL_K    = 2'd1,
    SEL_V    = 2'd2,
    SEL_RSVD = 2'd3
  } buf_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_STREAM = 2'd2,
    ST_FINISH = 2'd3
  } loader_state_e;

endpackage

// File: rtl/qkv_elem_buf.sv
// Single element buffer: one write port, one synchronous read port.
// Read data appears the cycle after i_re. Contents are never reset.
// Ports:
//   clk      : clock
//   i_we     : write strobe
//   i_waddr  : write index
//   i_wdata  : write value
//   i_re     : read enable
//   i_raddr  : read index
//   o_rdata  : registered read data
module qkv_elem_buf
  import attn_pkg::*;
#(
  parameter int DATA_WIDTH = ATTN_DATA_WIDTH,
  parameter int DEPTH      = ATTN_MAX_K,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_W-1:0]     i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_W-1:0]     i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/qkv_stream_loader.sv
// Q/K/V stream loader feeding the attention core.
// The host fills three element buffers; a start request launches the core
// (one-cycle core_start with the tile length) and then streams aligned
// (q[i], k[i], v[i]) triples over valid/ready at one triple per cycle.
// Ports:
//   clk, rst_n                   : clock, synchronous active-low reset
//   wr_en/wr_sel/wr_addr/wr_data : host buffer write port
//   start, k_len                 : launch request and requested tile length
//   clear_err                    : clears the sticky error flags
//   busy, done                   : pass in progress / end-of-pass pulse
//   len_err, wr_err              : sticky rejected-start / dropped-write flags
//   core_start, core_k_tile      : core launch pulse and effective length
//   out_valid, out_ready         : triple handshake to the core
//   q_data, k_data, v_data       : streamed elements
//   perf_stall_count             : saturating count of backpressured cycles
module qkv_stream_loader
  import attn_pkg::*;
#(
  parameter int DATA_WIDTH = ATTN_DATA_WIDTH,
  parameter int MAX_K      = ATTN_MAX_K,
  parameter int K_DEFAULT  = ATTN_K_DEFAULT,
  parameter int ADDR_W     = $clog2(MAX_K)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [1:0]            wr_sel,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  start,
  input  logic [15:0]           k_len,
  input  logic                  clear_err,
  output logic                  busy,
  output logic                  done,
  output logic                  len_err,
  output logic                  wr_err,
  output logic                  core_start,
  output logic [15:0]           core_k_tile,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] q_data,
  output logic [DATA_WIDTH-1:0] k_data,
  output logic [DATA_WIDTH-1:0] v_data,
  output logic [31:0]           perf_stall_count
);

  // Counters must reach MAX_K itself, hence one bit more than the address.
  localparam int CNT_W  = ADDR_W + 1;
  localparam int TRIP_W = 3 * DATA_WIDTH;

  loader_state_e r_state;
  loader_state_e w_state_next;

  logic [CNT_W-1:0]  r_len;
  logic [CNT_W-1:0]  r_rd_idx;
  logic [CNT_W-1:0]  r_hs_cnt;
  logic [15:0]       r_k_tile;
  logic              r_rd_vld;
  logic [TRIP_W-1:0] r_skid [2];
  logic [1:0]        r_skid_cnt;
  logic              r_len_err;
  logic              r_wr_err;
  logic [31:0]       r_stall;

  logic                  w_accept;
  logic                  w_reject;
  logic                  w_hs;
  logic                  w_last_hs;
  logic                  w_issue;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_wr_drop;
  logic [2:0]            w_occ;
  logic [1:0]            w_push_slot;
  logic [2:0]            w_buf_we;
  logic [DATA_WIDTH-1:0] w_rd_data [3];
  logic [TRIP_W-1:0]     w_rd_triple;
  logic [TRIP_W-1:0]     w_head;

  assign w_accept = (r_state == ST_IDLE) && start && (k_len <= 16'(MAX_K));
  assign w_reject = (r_state == ST_IDLE) && start && (k_len > 16'(MAX_K));

  // ---------------------------------------------------------------- buffers
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_buf
      assign w_buf_we[gi] = wr_en && !busy && (wr_sel == 2'(gi));
      qkv_elem_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (MAX_K),
        .ADDR_W     (ADDR_W)
      ) u_buf (
        .clk     (clk),
        .i_we    (w_buf_we[gi]),
        .i_waddr (wr_addr),
        .i_wdata (wr_data),
        .i_re    (w_issue),
        .i_raddr (r_rd_idx[ADDR_W-1:0]),
        .o_rdata (w_rd_data[gi])
      );
    end
  endgenerate

  assign w_wr_drop = wr_en && (busy || (wr_sel == SEL_RSVD));

  // ------------------------------------------------------- output staging
  // The head triple comes from the skid when it holds anything, otherwise
  // straight from the buffer read registers; this gives the first triple
  // one cycle after the LAUNCH read without an extra pipeline stage.
  assign w_rd_triple = {w_rd_data[0], w_rd_data[1], w_rd_data[2]};
  assign w_head      = (r_skid_cnt != 2'd0) ? r_skid[0] : w_rd_triple;
  assign out_valid   = (r_skid_cnt != 2'd0) || r_rd_vld;
  assign w_hs        = out_valid && out_ready;
  assign w_last_hs   = w_hs && (r_hs_cnt == (r_len - CNT_W'(1)));

  assign w_pop       = w_hs && (r_skid_cnt != 2'd0);
  // Fresh read data is parked unless it is handed over directly this cycle.
  assign w_push      = r_rd_vld && !((r_skid_cnt == 2'd0) && out_ready);
  assign w_push_slot = r_skid_cnt - 2'(w_pop);

  // Issue a read only if, counting the read in flight, the skid cannot
  // overflow: occupancy after this cycle's handshake must leave a free slot.
  assign w_occ   = {1'b0, r_skid_cnt} + {2'b00, r_rd_vld} - {2'b00, w_hs};
  assign w_issue = ((r_state == ST_LAUNCH) || (r_state == ST_STREAM)) &&
                   (r_rd_idx < r_len) && (w_occ <= 3'd1);

  assign q_data = out_valid ? w_head[TRIP_W-1 -: DATA_WIDTH]       : '0;
  assign k_data = out_valid ? w_head[2*DATA_WIDTH-1 -: DATA_WIDTH] : '0;
  assign v_data = out_valid ? w_head[DATA_WIDTH-1:0]               : '0;

  assign core_k_tile      = r_k_tile;
  assign len_err          = r_len_err;
  assign wr_err           = r_wr_err;
  assign perf_stall_count = r_stall;

  // -------------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    core_start   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_next = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        busy         = 1'b1;
        core_start   = 1'b1;
        w_state_next = ST_STREAM;
      end
      ST_STREAM: begin
        busy = 1'b1;
        if (w_last_hs) w_state_next = ST_FINISH;
      end
      ST_FINISH: begin
        busy         = 1'b1;
        done         = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // --------------------------------------------- control and status state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_len      <= '0;
      r_rd_idx   <= '0;
      r_hs_cnt   <= '0;
      r_k_tile   <= 16'(K_DEFAULT);
      r_rd_vld   <= 1'b0;
      r_skid_cnt <= 2'd0;
      r_len_err  <= 1'b0;
      r_wr_err   <= 1'b0;
      r_stall    <= '0;
    end else begin
      r_rd_vld   <= w_issue;
      r_skid_cnt <= r_skid_cnt - 2'(w_pop) + 2'(w_push);

      if (w_accept) begin
        r_len    <= (k_len == 16'd0) ? CNT_W'(K_DEFAULT) : k_len[CNT_W-1:0];
        r_k_tile <= (k_len == 16'd0) ? 16'(K_DEFAULT) : k_len;
        r_rd_idx <= '0;
        r_hs_cnt <= '0;
      end else begin
        if (w_issue) r_rd_idx <= r_rd_idx + CNT_W'(1);
        if (w_hs)    r_hs_cnt <= r_hs_cnt + CNT_W'(1);
      end

      // A new error in the same cycle as clear_err takes priority.
      if (w_reject)       r_len_err <= 1'b1;
      else if (clear_err) r_len_err <= 1'b0;
      if (w_wr_drop)      r_wr_err  <= 1'b1;
      else if (clear_err) r_wr_err  <= 1'b0;

      if (w_accept) begin
        r_stall <= '0;
      end else if ((r_state == ST_STREAM) && out_valid && !out_ready &&
                   (r_stall != '1)) begin
        r_stall <= r_stall + 32'd1;
      end
    end
  end

  // Skid storage is pure datapath; validity is tracked by r_skid_cnt.
  always_ff @(posedge clk) begin
    if (w_pop) r_skid[0] <= r_skid[1];
    if (w_push) begin
      if (w_push_slot == 2'd0) r_skid[0] <= w_rd_triple;
      else                     r_skid[1] <= w_rd_triple;
    end
  end

endmodule

// File: tb/tb_qkv_stream_loader.sv
// Self-checking bench for qkv_stream_loader. A behavioural model keeps
// array copies of the three buffers; streams are checked element by element
// against it, with inputs driven and outputs sampled on the falling edge.
module tb_qkv_stream_loader;
  import attn_pkg::*;

  localparam int DW   = ATTN_DATA_WIDTH;
  localparam int MAXK = ATTN_MAX_K;
  localparam int AW   = $clog2(MAXK);

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          wr_en     = 1'b0;
  logic [1:0]    wr_sel    = 2'd0;
  logic [AW-1:0] wr_addr   = '0;
  logic [DW-1:0] wr_data   = '0;
  logic          start     = 1'b0;
  logic [15:0]   k_len     = 16'd0;
  logic          clear_err = 1'b0;
  logic          out_ready = 1'b0;
  logic          busy, done, len_err, wr_err, core_start, out_valid;
  logic [15:0]   core_k_tile;
  logic [DW-1:0] q_data, k_data, v_data;
  logic [31:0]   perf_stall_count;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] qm [MAXK];
  logic [DW-1:0] km [MAXK];
  logic [DW-1:0] vm [MAXK];

  qkv_stream_loader dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .wr_en            (wr_en),
    .wr_sel           (wr_sel),
    .wr_addr          (wr_addr),
    .wr_data          (wr_data),
    .start            (start),
    .k_len            (k_len),
    .clear_err        (clear_err),
    .busy             (busy),
    .done             (done),
    .len_err          (len_err),
    .wr_err           (wr_err),
    .core_start       (core_start),
    .core_k_tile      (core_k_tile),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .q_data           (q_data),
    .k_data           (k_data),
    .v_data           (v_data),
    .perf_stall_count (perf_stall_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; the write is sampled at the next rising edge.
  task automatic write_elem(input int sel, input int addr, input logic [DW-1:0] data);
    wr_en   = 1'b1;
    wr_sel  = 2'(sel);
    wr_addr = AW'(addr);
    wr_data = data;
    @(negedge clk);
    wr_en = 1'b0;
    case (sel)
      0: qm[addr] = data;
      1: km[addr] = data;
      2: vm[addr] = data;
      default: ;
    endcase
  endtask

  // mode 0: ready always high, 1: ready pattern 1,0,0,1, 2: random ready.
  task automatic run_stream(input int klen, input int mode, input bit acc_wr, input bit busy_wr);
    int len, idx, cyc, stalls;
    bit prev_stall;
    logic rdy;
    logic [63:0] prev;
    len = (klen == 0) ? ATTN_K_DEFAULT : klen;
    start = 1'b1;
    k_len = 16'(klen);
    if (acc_wr) begin
      wr_en = 1'b1; wr_sel = 2'd0; wr_addr = '0; wr_data = DW'($urandom);
      qm[0] = wr_data;
    end
    @(negedge clk);
    start = 1'b0;
    wr_en = 1'b0;
    k_len = 16'($urandom);
    $display("stream: k_len=%0d mode=%0d len_eff=%0d", klen, mode, len);
    check("launch_core_start", 64'(core_start), 64'(1));
    check("launch_k_tile", 64'(core_k_tile), 64'(len));
    check("launch_busy", 64'(busy), 64'(1));
    check("launch_valid_low", 64'(out_valid), 64'(0));
    if (busy_wr) begin
      wr_en = 1'b1; wr_sel = 2'd0; wr_addr = '0; wr_data = ~qm[0];
    end
    idx = 0; cyc = 0; stalls = 0; prev_stall = 1'b0; prev = '0;
    while (idx < len && cyc < 8 * len + 16) begin
      @(negedge clk);
      wr_en = 1'b0;
      if (cyc == 0) check("first_valid", 64'(out_valid), 64'(1));
      if (prev_stall) begin
        check("stall_hold_valid", 64'(out_valid), 64'(1));
        check("stall_hold_data", 64'({q_data, k_data, v_data}), prev);
      end
      check("no_early_done", 64'(done), 64'(0));
      if (out_valid)
        check("triple", 64'({q_data, k_data, v_data}), 64'({qm[idx], km[idx], vm[idx]}));
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      out_ready  = rdy;
      prev_stall = out_valid && !rdy;
      if (out_valid && !rdy) stalls++;
      prev = 64'({q_data, k_data, v_data});
      if (out_valid && rdy) idx++;
      cyc++;
    end
    check("stream_count", 64'(idx), 64'(len));
    if (mode == 0) check("full_throughput", 64'(cyc), 64'(len));
    @(negedge clk);
    out_ready = 1'b0;
    check("done_pulse", 64'(done), 64'(1));
    check("valid_after_last", 64'(out_valid), 64'(0));
    check("perf_stall", 64'(perf_stall_count), 64'(stalls));
    @(negedge clk);
    check("done_one_cycle", 64'(done), 64'(0));
    check("busy_clear", 64'(busy), 64'(0));
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    $display("reset state");
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_core_start", 64'(core_start), 64'(0));
    check("rst_valid", 64'(out_valid), 64'(0));
    check("rst_len_err", 64'(len_err), 64'(0));
    check("rst_wr_err", 64'(wr_err), 64'(0));
    check("rst_k_tile", 64'(core_k_tile), 64'(ATTN_K_DEFAULT));
    check("rst_perf", 64'(perf_stall_count), 64'(0));
    check("rst_data", 64'({q_data, k_data, v_data}), 64'(0));
    rst_n = 1'b1;

    for (int i = 0; i < MAXK; i++)
      for (int s = 0; s < 3; s++)
        write_elem(s, i, DW'($urandom));
    for (int i = 0; i < 4; i++) begin
      write_elem(0, i, DW'(i + 1));
      write_elem(1, i, DW'(2));
      write_elem(2, i, DW'(16'h0100));
    end

    run_stream(4, 0, 1'b0, 1'b0);
    run_stream(0, 0, 1'b0, 1'b0);

    // Oversized length: rejected, sticky error, clear, error-wins-over-clear.
    start = 1'b1; k_len = 16'd65;
    @(negedge clk);
    start = 1'b0;
    $display("reject k_len=65");
    check("len_err_set", 64'(len_err), 64'(1));
    check("reject_busy", 64'(busy), 64'(0));
    check("reject_no_core_start", 64'(core_start), 64'(0));
    @(negedge clk);
    check("reject_still_idle", 64'({busy, core_start, out_valid}), 64'(0));
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    check("len_err_cleared", 64'(len_err), 64'(0));
    clear_err = 1'b1; start = 1'b1; k_len = 16'($urandom_range(65, 65535));
    @(negedge clk);
    clear_err = 1'b0; start = 1'b0;
    check("len_err_wins", 64'(len_err), 64'(1));
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    check("len_err_cleared2", 64'(len_err), 64'(0));

    run_stream(8, 1, 1'b0, 1'b0);

    // Write while busy is dropped and flagged.
    run_stream(8, 2, 1'b0, 1'b1);
    check("wr_err_busy", 64'(wr_err), 64'(1));
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    check("wr_err_cleared", 64'(wr_err), 64'(0));
    write_elem(3, 5, DW'($urandom));
    $display("reserved write");
    check("wr_err_rsvd", 64'(wr_err), 64'(1));
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    run_stream(8, 0, 1'b0, 1'b0);

    // Maximum length, write in the accept cycle, random backpressure.
    run_stream(MAXK, 2, 1'b1, 1'b0);

    // Reset in the middle of a stream.
    start = 1'b1; k_len = 16'd8; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    $display("reset mid-stream");
    check("pre_reset_triple", 64'({q_data, k_data, v_data}), 64'({qm[3], km[3], vm[3]}));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b0;
    check("mid_rst_valid", 64'(out_valid), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_k_tile", 64'(core_k_tile), 64'(ATTN_K_DEFAULT));
    for (int i = 0; i < 3; i++) begin
      check("mid_rst_no_done", 64'({done, out_valid}), 64'(0));
      @(negedge clk);
    end
    run_stream(5, 0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
